riscv_checkpoint_monitor: RTL

- Synthesizable self-check monitor for the RISC-V core test flow.
- Watches the core's NUM_INST, OUTPUT_PORT and HALT, and compares OUTPUT_PORT against a loadable table of (instruction-count, expected-value) checkpoints.
- Reports pass/fail/timeout status, the failing checkpoint index and the offending value.
- Sits beside RISCV_TOP in benches and FPGA test wrappers, so pass/fail can be read without simulator $display/$finish.

---
 rtl/riscv_checkpoint_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_checkpoint_monitor.sv
// ============================================================================
// riscv_checkpoint_monitor : checks a core's OUTPUT_PORT against a table of
// (instruction-count, expected-value) checkpoints and reports pass/fail.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_checkpoint_monitor #(
  parameter int NUM_TEST     = 17,
  parameter int IDX_W        = 5,
  parameter int DWIDTH       = 32,
  parameter int CWIDTH       = 32,
  parameter int TIMEOUT      = 100000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TBL_WE,
  input  logic [IDX_W-1:0]  TBL_ADDR,
  input  logic [DWIDTH-1:0] TBL_NUM_INST,
  input  logic [DWIDTH-1:0] TBL_ANS,
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              FAIL,
  output logic [1:0]        FAIL_CODE,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VALUE,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [IDX_W:0]    FAIL_CNT,
  output logic [CWIDTH-1:0] CYCLE
);

  localparam logic [IDX_W:0]    C_NUM_TEST   = (IDX_W+1)'(NUM_TEST);
  localparam logic [CWIDTH-1:0] C_TIMEOUT_M1 = CWIDTH'(TIMEOUT - 1);

  localparam logic [1:0] C_CODE_NONE     = 2'd0;
  localparam logic [1:0] C_CODE_MISMATCH = 2'd1;
  localparam logic [1:0] C_CODE_MISSED   = 2'd2;
  localparam logic [1:0] C_CODE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W:0]      ptr_q, ptr_d;
  logic [IDX_W:0]      pass_cnt_q, pass_cnt_d;
  logic [IDX_W:0]      fail_cnt_q, fail_cnt_d;
  logic [CWIDTH-1:0]   cycle_q, cycle_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic [IDX_W-1:0]    fail_idx_q, fail_idx_d;
  logic [DWIDTH-1:0]   fail_value_q, fail_value_d;

  // Checkpoint table: no reset, so a loaded table survives RST.
  logic [DWIDTH-1:0]   tbl_num_q [NUM_TEST];
  logic [DWIDTH-1:0]   tbl_ans_q [NUM_TEST];

  logic                tbl_wr_en;
  logic                ptr_valid;
  logic [IDX_W-1:0]    rd_idx;
  logic [DWIDTH-1:0]   cp_num;
  logic [DWIDTH-1:0]   cp_ans;
  logic                cp_fail;
  logic [1:0]          cp_code;

  assign tbl_wr_en = TBL_WE && (state_q != S_RUN) && ({1'b0, TBL_ADDR} < C_NUM_TEST);
  assign ptr_valid = (ptr_q < C_NUM_TEST);
  assign rd_idx    = ptr_valid ? ptr_q[IDX_W-1:0] : '0;
  assign cp_num    = tbl_num_q[rd_idx];
  assign cp_ans    = tbl_ans_q[rd_idx];

  always_ff @(posedge CLK) begin
    if (tbl_wr_en) begin
      tbl_num_q[TBL_ADDR] <= TBL_NUM_INST;
      tbl_ans_q[TBL_ADDR] <= TBL_ANS;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    cycle_d      = cycle_q;
    fail_code_d  = fail_code_q;
    fail_idx_d   = fail_idx_q;
    fail_value_d = fail_value_q;
    cp_fail      = 1'b0;
    cp_code      = C_CODE_NONE;

    case (state_q)
      S_RUN: begin
        cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

        if (ptr_valid) begin
          if (NUM_INST == cp_num) begin
            if (OUTPUT_PORT == cp_ans) begin
              pass_cnt_d = pass_cnt_q + 1'b1;
              ptr_d      = ptr_q + 1'b1;
            end else begin
              cp_fail = 1'b1;
              cp_code = C_CODE_MISMATCH;
            end
          end else if (NUM_INST > cp_num) begin
            cp_fail = 1'b1;
            cp_code = C_CODE_MISSED;
          end
        end

        if (cp_fail) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_code_q == C_CODE_NONE) begin
            fail_code_d  = cp_code;
            fail_idx_d   = ptr_q[IDX_W-1:0];
            fail_value_d = OUTPUT_PORT;
          end
          if (STOP_ON_FAIL != 0) begin
            state_d = S_FAIL;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end

        // HALT and timeout see the counters as updated by this cycle's checkpoint.
        if (state_d == S_RUN) begin
          if (HALT) begin
            if ((ptr_d == C_NUM_TEST) && (fail_cnt_d == '0)) begin
              state_d = S_PASS;
            end else begin
              state_d = S_FAIL;
              if (fail_code_d == C_CODE_NONE) begin
                fail_code_d  = C_CODE_MISSED;
                fail_idx_d   = ptr_d[IDX_W-1:0];
                fail_value_d = OUTPUT_PORT;
              end
            end
          end else if (cycle_d >= C_TIMEOUT_M1) begin
            state_d = S_FAIL;
            if (fail_code_d == C_CODE_NONE) begin
              fail_code_d  = C_CODE_TIMEOUT;
              fail_idx_d   = ptr_d[IDX_W-1:0];
              fail_value_d = OUTPUT_PORT;
            end
          end
        end
      end

      default: begin
        // IDLE clears continuously; PASS/FAIL hold their status until START.
        if ((state_q == S_IDLE) || START) begin
          ptr_d        = '0;
          pass_cnt_d   = '0;
          fail_cnt_d   = '0;
          cycle_d      = '0;
          fail_code_d  = C_CODE_NONE;
          fail_idx_d   = '0;
          fail_value_d = '0;
        end
        if (START) begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      cycle_q      <= '0;
      fail_code_q  <= C_CODE_NONE;
      fail_idx_q   <= '0;
      fail_value_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      cycle_q      <= cycle_d;
      fail_code_q  <= fail_code_d;
      fail_idx_q   <= fail_idx_d;
      fail_value_q <= fail_value_d;
    end
  end

  assign BUSY       = (state_q == S_RUN);
  assign PASS       = (state_q == S_PASS);
  assign FAIL       = (state_q == S_FAIL);
  assign DONE       = PASS || FAIL;
  assign FAIL_CODE  = fail_code_q;
  assign FAIL_IDX   = fail_idx_q;
  assign FAIL_VALUE = fail_value_q;
  assign PASS_CNT   = pass_cnt_q;
  assign FAIL_CNT   = fail_cnt_q;
  assign CYCLE      = cycle_q;

endmodule

`default_nettype wire
